// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the mux select sequencer and its picker.
package mux_sel_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DWELL,
        ST_GAP
    } state_e;

    function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] sel);
        return NCH'(1) << sel;
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_rr_pick.sv
// Combinational rotating-priority picker: searches from ptr+1 around to ptr.
module rr_pick
    import mux_sel_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] pick,
    output logic            any
);

    logic            found;
    logic [SELW-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        // i = NCH wraps back to ptr itself, so the last grantee is tried last
        for (int i = 1; i <= NCH; i++) begin
            idx = ptr + SELW'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin select sequencer driving the 4:1 mux select, with fixed dwell,
// capture strobe on the last dwell cycle and a one-cycle guard gap.
module mux_sel_sequencer
    import mux_sel_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NCH-1:0]  req,
    output logic [SELW-1:0] s,
    output logic [NCH-1:0]  grant,
    output logic            valid,
    output logic            sample,
    output logic            busy
);

    localparam int              CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(DWELL - 1);

    state_e          state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [SELW-1:0] s_q, s_d;
    logic [NCH-1:0]  grant_q, grant_d;
    logic            valid_q, valid_d;
    logic            sample_q, sample_d;
    logic            busy_q, busy_d;

    logic [SELW-1:0] pick;
    logic            pick_any;

    rr_pick u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        sample_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (en && pick_any) begin
                    state_d  = ST_DWELL;
                    s_d      = pick;
                    ptr_d    = pick;
                    cnt_d    = CNT_LOAD;
                    grant_d  = onehot(pick);
                    valid_d  = 1'b1;
                    sample_d = (CNT_LOAD == '0);
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            ST_DWELL: begin
                // Outputs are registered, so sample is raised one edge ahead
                // of the cycle in which the counter reads zero.
                if (!req[s_q] || (cnt_q == '0)) begin
                    state_d = ST_GAP;
                    grant_d = '0;
                    valid_d = 1'b0;
                end else begin
                    cnt_d    = cnt_q - CNTW'(1);
                    sample_d = (cnt_q == CNTW'(1));
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= SELW'(NCH - 1);
            cnt_q    <= '0;
            s_q      <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
        end
    end

    assign s      = s_q;
    assign grant  = grant_q;
    assign valid  = valid_q;
    assign sample = sample_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer: one instance with DWELL=4, one with DWELL=1.
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst4, en4, rst1, en1;
    logic [3:0] req4, req1;
    logic [1:0] s4, s1;
    logic [3:0] grant4, grant1;
    logic       valid4, sample4, busy4, valid1, sample1, busy1;

    int num_checks   = 0;
    int num_failures = 0;

    always #5 clk = ~clk;

    mux_sel_sequencer #(.DWELL(4)) dut4 (
        .clk (clk), .rst (rst4), .en (en4), .req (req4),
        .s (s4), .grant (grant4), .valid (valid4), .sample (sample4), .busy (busy4)
    );

    mux_sel_sequencer #(.DWELL(1)) dut1 (
        .clk (clk), .rst (rst1), .en (en1), .req (req1),
        .s (s1), .grant (grant1), .valid (valid1), .sample (sample1), .busy (busy1)
    );

    // Packed view {s, grant, valid, sample, busy}
    function automatic logic [8:0] exp_out(input logic [1:0] sel, input logic v,
                                           input logic smp, input logic b);
        logic [3:0] g;
        g = v ? (4'b0001 << sel) : 4'b0000;
        return {sel, g, v, smp, b};
    endfunction

    task automatic checkOutput(input string tag, input logic [8:0] observed,
                               input logic [8:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_failures++;
            $display("[TB] FAIL %s: got s/grant/valid/sample/busy=%b, expected %b",
                     tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int which, input logic r, input logic e,
                                 input logic [3:0] q);
        if (which == 4) begin
            rst4 = r; en4 = e; req4 = q;
        end else begin
            rst1 = r; en1 = e; req1 = q;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [8:0] expected);
        checkOutput(tag, {s4, grant4, valid4, sample4, busy4}, expected);
    endtask

    task automatic check1(input string tag, input logic [8:0] expected);
        checkOutput(tag, {s1, grant1, valid1, sample1, busy1}, expected);
    endtask

    // Four dwell cycles of channel ch, then the guard gap; next_req is
    // applied before the gap so the following pick sees it.
    task automatic run_grant(input logic [1:0] ch, input logic [3:0] next_req);
        for (int k = 0; k < 4; k++) begin
            tick();
            check4($sformatf("dwell ch%0d c%0d", ch, k), exp_out(ch, 1'b1, k == 3, 1'b1));
        end
        req4 = next_req;
        tick();
        check4($sformatf("gap after ch%0d", ch), exp_out(ch, 1'b0, 1'b0, 1'b1));
    endtask

    initial begin
        applyStimulus(4, 1'b1, 1'b1, 4'b1111);
        applyStimulus(1, 1'b1, 1'b1, 4'b0001);

        tick();
        tick();
        check4("reset4", exp_out(2'd0, 1'b0, 1'b0, 1'b0));

        applyStimulus(4, 1'b0, 1'b1, 4'b1111);
        run_grant(2'd0, 4'b1111);
        run_grant(2'd1, 4'b1111);
        run_grant(2'd2, 4'b1111);
        run_grant(2'd3, 4'b1111);
        run_grant(2'd0, 4'b1010);

        run_grant(2'd1, 4'b1010);
        run_grant(2'd3, 4'b1010);
        run_grant(2'd1, 4'b1010);
        run_grant(2'd3, 4'b0100);

        tick(); check4("drop d1", exp_out(2'd2, 1'b1, 1'b0, 1'b1));
        tick(); check4("drop d2", exp_out(2'd2, 1'b1, 1'b0, 1'b1));
        req4 = 4'b1000;
        tick(); check4("drop gap", exp_out(2'd2, 1'b0, 1'b0, 1'b1));
        tick(); check4("after drop ch3", exp_out(2'd3, 1'b1, 1'b0, 1'b1));

        tick(); check4("en d2", exp_out(2'd3, 1'b1, 1'b0, 1'b1));
        en4 = 1'b0;
        tick(); check4("en d3", exp_out(2'd3, 1'b1, 1'b0, 1'b1));
        tick(); check4("en d4 sample", exp_out(2'd3, 1'b1, 1'b1, 1'b1));
        tick(); check4("en gap", exp_out(2'd3, 1'b0, 1'b0, 1'b1));
        tick(); check4("en idle", exp_out(2'd3, 1'b0, 1'b0, 1'b0));
        req4 = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            tick(); check4($sformatf("en low idle %0d", k), exp_out(2'd3, 1'b0, 1'b0, 1'b0));
        end

        en4 = 1'b1;
        tick(); check4("pre-rst d1", exp_out(2'd0, 1'b1, 1'b0, 1'b1));
        tick(); check4("pre-rst d2", exp_out(2'd0, 1'b1, 1'b0, 1'b1));
        rst4 = 1'b1;
        tick(); check4("mid-dwell rst", exp_out(2'd0, 1'b0, 1'b0, 1'b0));
        rst4 = 1'b0;
        tick(); check4("post-rst ch0", exp_out(2'd0, 1'b1, 1'b0, 1'b1));

        check1("reset1", exp_out(2'd0, 1'b0, 1'b0, 1'b0));
        applyStimulus(1, 1'b0, 1'b1, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            tick(); check1($sformatf("d1 dwell %0d", k), exp_out(2'd0, 1'b1, 1'b1, 1'b1));
            tick(); check1($sformatf("d1 gap %0d", k), exp_out(2'd0, 1'b0, 1'b0, 1'b1));
        end
        tick(); check1("d1 pre-rst", exp_out(2'd0, 1'b1, 1'b1, 1'b1));
        applyStimulus(1, 1'b1, 1'b1, 4'b1111);
        tick(); check1("d1 rst", exp_out(2'd0, 1'b0, 1'b0, 1'b0));
        applyStimulus(1, 1'b0, 1'b1, 4'b1111);
        tick(); check1("d1 post-rst ch0", exp_out(2'd0, 1'b1, 1'b1, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_failures);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
# mux_sel_sequencer

Round-robin select sequencer that sits directly upstream of the 4-bit 4:1 multiplexer and drives its 2-bit select `s`. It scans four requesting channels, holds each granted channel on the mux for a fixed dwell time, and emits a one-cycle `sample` strobe so the downstream register can capture the mux output `y`. Idle channels are skipped, and a one-cycle guard gap separates consecutive grants so the mux output settles before `valid` reasserts.

## Interface
- `DWELL`, default 4: cycles each grant holds `s`; legal range 1..16.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `en` input, 1 bit: permits new grants; a dwell already in progress always completes.
- `req` input, 4 bits: per-channel request; bit k corresponds to mux input i(k+1).
- `s` output, 2 bits: mux select (index of the granted channel).
- `grant` output, 4 bits: one-hot copy of `s`; all zeros when nothing is granted.
- `valid` output, 1 bit: mux output is valid for channel `s`.
- `sample` output, 1 bit: single-cycle capture strobe on the last dwell cycle.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, DWELL and GAP.
- **IDLE.** If `en`=1 and `req`≠0, pick the next channel and go to DWELL. Otherwise remain in IDLE.
- **Pick rule.** Rotating priority starts at `ptr`+1 mod 4, where `ptr` is the last granted channel. Ties are impossible because the search order is fixed.
- **Entering DWELL:**
  - `s` = picked channel, `grant` = one-hot of it, `valid`=1, `ptr` = picked channel.
  - The counter loads DWELL-1.
- **DWELL, counter>0.** Decrement the counter and hold `s`.
- **DWELL, counter=0.** Assert `sample`=1 for this cycle, then go to GAP.
- **Early drop.** If `req[s]`=0 while in DWELL, the next state is GAP with no `sample`. The drop is evaluated before the counter check, so a drop on the final cycle suppresses `sample`.
- **GAP:**
  - `valid`=0, `grant`=0, `s` holds its value.
  - If `en`=1 and `req`≠0, re-pick (rotation from `ptr`) and enter DWELL next cycle.
  - Otherwise go to IDLE.
- **`en` behaviour.** `en` is sampled only in IDLE and GAP. Dropping `en` mid-dwell does not truncate the dwell.
- **Requests.** A request raised while another channel is dwelling waits for GAP; there is no preemption.
- **Counter width.** The counter is $clog2(DWELL) bits, minimum 1. With DWELL=1, `sample` asserts on the first and only dwell cycle.

## Timing
- **Reset values** (`rst` high at a rising edge):
  - State IDLE; `s`=2'b00, `grant`=4'b0000, `valid`=0, `sample`=0, `busy`=0.
  - `ptr`=3, so channel 0 has first priority; counter=0.
- **Registering.** All outputs are registered, with no combinational path from `req` or `en` to any output.
- **Grant latency.** `req` seen in IDLE at edge N gives `valid`/`grant` at edge N+1.
- **Grant period.** A full grant occupies DWELL cycles with `valid`=1, plus 1 GAP cycle. Back-to-back requests therefore give a grant period of DWELL+1 cycles.
- **`sample` position.** `sample` coincides with the last `valid` cycle and never asserts while `valid`=0.
- **Reset mid-operation.** Reset mid-dwell aborts immediately with no `sample`. `ptr` returns to 3.
- **Simultaneous events.** `rst` has priority over all other inputs.

## Structure
- Package `mux_sel_pkg` holds:
  - the state enum IDLE/DWELL/GAP;
  - constant NCH=4;
  - the select width constant SELW=2.
- Sub-module `rr_pick` is a combinational rotating-priority picker.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `pick[1:0]`, `any`.
  - It is instantiated once; the top level contains the FSM, counter and output registers.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with `req`=4'b1111 → `s`=0, `grant`=0, `valid`=0, `busy`=0. First grant after release is channel 0, `valid` at the edge after `rst` drops.
- **Full rotation.** `req`=4'b1111, `en`=1, DWELL=4 → grant order 0,1,2,3,0. Each grant has 4 `valid` cycles with `sample` on the 4th, separated by 1-cycle gaps; period is 5 cycles.
- **Idle skip.** `req`=4'b1010 → grants alternate 1,3,1,3. Channels 0 and 2 never appear on `s`.
- **Early drop.** Grant channel 2, then drop `req[2]` after 2 dwell cycles → GAP follows with no `sample` pulse. Next grant is channel 3 if requested.
- **`en` behaviour.**
  - Drop `en` during the 2nd dwell cycle → dwell completes with `sample`, then IDLE.
  - With `en` held low and `req`=4'b1111 → `busy` stays 0.
- **Reset mid-dwell.** With DWELL=1, reset during a dwell → no `sample`; next grant after release is channel 0.
- **Single-cycle dwell.** With DWELL=1 and `req`=4'b0001 → `valid` and `sample` both pulse 1 cycle in every 2.
